// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: write-back select codes, WB FSM states and load-select helper shared by WB and the EX forwarding path
package wb_stage_pkg;
  localparam logic [1:0] RF_WSEL_ALU = 2'd0;
  localparam logic [1:0] RF_WSEL_PC4 = 2'd1;
  localparam logic [1:0] RF_WSEL_EXT = 2'd2;
  localparam logic [1:0] RF_WSEL_RDO = 2'd3;
  typedef enum logic [1:0] {WB_IDLE, WB_RES, WB_WAIT} wb_state_e;
  function automatic logic is_load(input logic [1:0] wsel);
    return wsel == RF_WSEL_RDO;
  endfunction
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM->WB instruction handoff (in_valid/in_ready, pc, pc4, alu_c, ext, wsel, we, wR); master=MEM, slave=WB
interface wb_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_alu_c;
  logic [XLEN-1:0] in_ext;
  logic [1:0]      in_wsel;
  logic            in_we;
  logic [4:0]      in_wR;
  modport master(output in_valid, in_pc, in_pc4, in_alu_c, in_ext, in_wsel, in_we, in_wR, input in_ready);
  modport slave(input in_valid, in_pc, in_pc4, in_alu_c, in_ext, in_wsel, in_we, in_wR, output in_ready);
endinterface

// File: rtl/wb_result_mux.sv
// wb_result_mux: selects write-back data from wsel (alu_c/pc4/ext/rdo in, wd out; unknown code gives 0)
module wb_result_mux
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      wsel,
  input  logic [XLEN-1:0] alu_c,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] ext,
  input  logic [XLEN-1:0] rdo,
  output logic [XLEN-1:0] wd
);
  always_comb
    wd = wsel == RF_WSEL_ALU ? alu_c :
         wsel == RF_WSEL_PC4 ? pc4 :
         wsel == RF_WSEL_EXT ? ext :
         wsel == RF_WSEL_RDO ? rdo : '0;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32 write-back stage; clk/rst_n, mem (slave handoff from MEM), dram_rvalid/dram_rdo in; rf_we/rf_wR/rf_wD, load_err, debug_wb_* out
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_stage_if.slave       mem,
  input  logic            dram_rvalid,
  input  logic [XLEN-1:0] dram_rdo,
  output logic            rf_we,
  output logic [4:0]      rf_wR,
  output logic [XLEN-1:0] rf_wD,
  output logic            load_err,
  output logic            debug_wb_have_inst,
  output logic [XLEN-1:0] debug_wb_pc,
  output logic            debug_wb_ena,
  output logic [4:0]      debug_wb_reg,
  output logic [XLEN-1:0] debug_wb_value
);
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  wb_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d, alu_c_q, alu_c_d, ext_q, ext_d;
  logic [1:0]      wsel_q, wsel_d;
  logic            we_q, we_d, err_q, err_d;
  logic [4:0]      wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready, take, retire, timeout, stray, waiting;
  logic [XLEN-1:0] mux_wd;
  wb_result_mux #(.XLEN(XLEN)) u_mux (
    .wsel (wsel_q),
    .alu_c(alu_c_q),
    .pc4  (pc4_q),
    .ext  (ext_q),
    .rdo  (dram_rdo),
    .wd   (mux_wd)
  );
  assign mem.in_ready = ready;
  always_comb begin
    waiting = state_q == WB_WAIT && !dram_rvalid;
    timeout = waiting && cnt_q == CW'(LOAD_TIMEOUT);
    stray   = dram_rvalid && state_q != WB_WAIT;
    retire  = rst_n && (state_q == WB_RES || (state_q == WB_WAIT && (dram_rvalid || timeout)));
    ready   = rst_n && !waiting;
    take    = mem.in_valid && ready;
    state_d = take ? (is_load(mem.in_wsel) ? WB_WAIT : WB_RES) : retire ? WB_IDLE : state_q;
    cnt_d   = take ? '0 : (waiting && !timeout) ? cnt_q + CW'(1) : cnt_q;
    err_d   = err_q || timeout || stray;
    pc_d    = take ? mem.in_pc : pc_q;
    pc4_d   = take ? mem.in_pc4 : pc4_q;
    alu_c_d = take ? mem.in_alu_c : alu_c_q;
    ext_d   = take ? mem.in_ext : ext_q;
    wsel_d  = take ? mem.in_wsel : wsel_q;
    we_d    = take ? mem.in_we : we_q;
    wr_d    = take ? mem.in_wR : wr_q;
    rf_we   = retire && we_q && wr_q != 5'd0 && !timeout;
    rf_wR   = retire ? wr_q : '0;
    rf_wD   = retire ? mux_wd : '0;
    load_err = rst_n && (err_q || timeout || stray);
    debug_wb_have_inst = retire;
    debug_wb_pc    = retire ? pc_q : '0;
    debug_wb_ena   = rf_we;
    debug_wb_reg   = rf_wR;
    debug_wb_value = rf_wD;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      alu_c_q <= '0;
      ext_q   <= '0;
      wsel_q  <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      alu_c_q <= alu_c_d;
      ext_q   <= ext_d;
      wsel_q  <= wsel_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
    end
endmodule
